// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared bus types, chip-enable levels, reset PC and FSM state encodings
// for the instruction-fetch slice.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam logic       CHIP_ENABLE      = 1'b1;
  localparam logic       CHIP_DISABLE     = 1'b0;
  localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Prioritised redirect: flush, then a branch parked during a stall, then a live branch.
  function automatic inst_addr_t calc_next_pc(
    input logic       flush,
    input inst_addr_t flush_pc,
    input logic       pend_valid,
    input inst_addr_t pend_target,
    input logic       branch,
    input inst_addr_t branch_target,
    input inst_addr_t pc,
    input inst_addr_t step
  );
    if (flush)      return flush_pc;
    if (pend_valid) return pend_target;
    if (branch)     return branch_target;
    return pc + step;
  endfunction

endpackage

// File: rtl/if_fetch_if_id_reg.sv
// if_fetch_if_id_reg: IF/ID boundary register. A flush clears the slot, a kill only
// drops valid, and a capture loads the fetched {pc, inst}.
module if_fetch_if_id_reg
  import if_fetch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_kill,
  input  logic       i_capture,
  input  inst_addr_t i_pc,
  input  inst_t      i_inst,
  output inst_addr_t o_id_pc,
  output inst_t      o_id_inst,
  output logic       o_id_valid
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_id_pc    <= '0;
      o_id_inst  <= '0;
      o_id_valid <= 1'b0;
    end else if (i_clear) begin
      o_id_inst  <= '0;
      o_id_valid <= 1'b0;
    end else if (i_kill) begin
      o_id_valid <= 1'b0;
    end else if (i_capture) begin
      o_id_pc    <= i_pc;
      o_id_inst  <= i_inst;
      o_id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC/FSM for instruction fetch with stall, delayed branch and flush.
// Optional misaligned-PC exception enabled by defining IF_MISALIGN_EXC_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter inst_addr_t PC_STEP  = 32'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_stall,
  input  logic       i_flush,
  input  inst_addr_t i_flush_pc,
  input  logic       i_branch_flag,
  input  inst_addr_t i_branch_target,
  output logic       o_rom_ce,
  output inst_addr_t o_rom_addr,
  input  inst_t      i_rom_inst,
  output inst_addr_t o_id_pc,
  output inst_t      o_id_inst,
  output logic       o_id_valid
`ifdef IF_MISALIGN_EXC_EN
  ,
  output logic       o_fetch_exc,
  output inst_addr_t o_fetch_bad_addr
`endif
);

  fetch_state_t r_state;
  inst_addr_t   r_pc;
  inst_addr_t   r_pend_target;
  logic         r_pend_valid;
  logic         r_rom_ce;

  inst_addr_t   w_next_pc;
  logic         w_active;
  logic         w_capture;
  logic         w_clear;
  logic         w_kill;

  assign w_active   = (r_state != S_IDLE);
  assign o_rom_addr = r_pc;
  assign w_next_pc  = calc_next_pc(i_flush, i_flush_pc, r_pend_valid, r_pend_target,
                                   i_branch_flag, i_branch_target, r_pc, PC_STEP);

`ifdef IF_MISALIGN_EXC_EN
  logic       r_fetch_exc;
  inst_addr_t r_fetch_bad_addr;
  logic       w_misalign;

  // A misaligned PC never reaches the ROM; it parks here until a flush redirects it.
  assign w_misalign       = w_active && (r_pc[1:0] != 2'b00);
  assign w_kill           = w_misalign && !i_flush;
  assign o_rom_ce         = r_rom_ce & ~w_misalign;
  assign o_fetch_exc      = r_fetch_exc;
  assign o_fetch_bad_addr = r_fetch_bad_addr;
`else
  assign w_kill   = 1'b0;
  assign o_rom_ce = r_rom_ce;
`endif

  assign w_clear   = w_active && i_flush;
  assign w_capture = w_active && !i_flush && !i_stall && !w_kill && (o_rom_ce == CHIP_ENABLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_rom_ce      <= CHIP_DISABLE;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
`ifdef IF_MISALIGN_EXC_EN
      r_fetch_exc      <= 1'b0;
      r_fetch_bad_addr <= '0;
`endif
    end else if (r_state == S_IDLE) begin
      r_state  <= S_RUN;
      r_rom_ce <= CHIP_ENABLE;
      if (i_flush) r_pc <= i_flush_pc;
    end else if (i_flush) begin
      r_state      <= S_RUN;
      r_pc         <= w_next_pc;
      r_pend_valid <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
      r_fetch_exc  <= 1'b0;
    end else if (w_misalign) begin
      r_fetch_exc      <= 1'b1;
      r_fetch_bad_addr <= r_pc;
`endif
    end else if (i_stall) begin
      // A branch resolved during a stall is parked and applied on the first free cycle.
      r_state <= S_HOLD;
      if (i_branch_flag) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= i_branch_target;
      end
    end else begin
      r_state      <= S_RUN;
      r_pc         <= w_next_pc;
      r_pend_valid <= 1'b0;
    end
  end

  if_fetch_if_id_reg u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_kill     (w_kill),
    .i_capture  (w_capture),
    .i_pc       (r_pc),
    .i_inst     (i_rom_inst),
    .o_id_pc    (o_id_pc),
    .o_id_inst  (o_id_inst),
    .o_id_valid (o_id_valid)
  );

endmodule
